if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction fetch stage of the pipeline: owns the program counter, issues requests to instruction memory, and produces the PC/instruction pair consumed by the IF/ID pipeline register. It applies branch/jump redirects, returns from interrupt (mret), and vectors to the interrupt handler. A one-entry skid buffer absorbs a memory response that arrives while decode is stalled.

## Interface

- RESET_PC, 32'h0000_0000, PC fetched first after reset
- IRQ_VECTOR, 32'h0000_0100, handler entry address
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- stall  in  1  downstream not accepting; hold outputs
- redirect_valid  in  1  taken branch/jump from EX
- redirect_pc  in  32  redirect target
- mret  in  1  return from interrupt, target = epc
- irq  in  1  level-sensitive interrupt request
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  imem_rdata valid for imem_addr this cycle
- imem_rdata  in  32  fetched instruction
- pc_out  out  32  PC of delivered instruction
- instruction_out  out  32  delivered instruction
- valid_out  out  1  pc_out/instruction_out valid
- epc  out  32  saved return PC
- in_isr  out  1  handler executing; masks irq
- irq_ack  out  1  one-cycle pulse when trap taken

## Operation

- States: BOOT, FETCH, HOLD. Reset enters BOOT; BOOT -> FETCH after one cycle with imem_req=0.
- Internal `outstanding` flag: set when imem_req=1 and imem_ready=0; cleared on imem_ready or on any redirect/mret.
- FETCH: imem_req = !stall | outstanding; imem_addr = pc, stable while outstanding.
  - imem_ready & !stall: deliver (pc_out<=pc, instruction_out<=imem_rdata, valid_out<=1), advance PC.
  - imem_ready & stall: capture pc/rdata in skid buffer -> HOLD, PC advances.
  - no delivery & !stall: valid_out<=0 (bubble).
  - stall: all outputs hold.
- HOLD: imem_req=0. When stall drops, deliver buffer contents -> FETCH.
- PC advance priority, evaluated every cycle: redirect_valid > mret > irq trap > sequential (pc+4, mod 2^32 wrap).
- redirect_valid: pc<=redirect_pc, valid_out<=0, buffer discarded, outstanding cleared, state -> FETCH. Overrides stall. An abandoned memory access is discarded; memory must tolerate a changed address.
- mret (no redirect): same as redirect with target epc; in_isr<=0.
- irq trap: taken on a delivery cycle (FETCH ready & !stall, or HOLD & !stall) when irq & !in_isr & no redirect/mret. The delivered instruction still goes out; epc<=address of next sequential instruction; pc<=IRQ_VECTOR; in_isr<=1; irq_ack=1 for that cycle.
- irq while in_isr=1: ignored until mret.

## Timing

- Reset values: pc=RESET_PC, pc_out=0, instruction_out=0, valid_out=0, epc=0, in_isr=0, irq_ack=0, imem_req=0, state BOOT.
- First imem_req asserted in the second cycle after reset deasserts.
- Latency: valid_out asserts on the clock edge after imem_ready & !stall.
- Back-to-back throughput: one instruction per cycle when imem_ready is held high and stall=0.
- Redirect/mret: valid_out=0 from the next edge; the first target fetch is issued in the cycle after the redirect.
- irq_ack is registered: high exactly one cycle, coincident with valid_out of the last pre-trap instruction.
- Reset mid-operation: immediate return to reset values; the buffer and outstanding state are lost.

## Configuration

- IF_IRQ_EN defined: interrupt, mret, epc, and in_isr logic present as above.
- IF_IRQ_EN undefined: irq and mret are ignored; epc, in_isr, and irq_ack are tied to 0; priority reduces to redirect > sequential.

## Test plan

- Reset, imem_ready=1, stall=0 -> deliveries pc_out 0x0, 0x4, 0x8 on consecutive cycles starting one cycle after the first imem_req.
- imem_ready at pc 0x8 with stall=1 for 3 cycles -> HOLD; imem_req=0; outputs held; on stall release, pc_out=0x8 is delivered, then 0xC is fetched.
- redirect_valid with redirect_pc=0x40 while in HOLD and stall=1 -> valid_out=0 next edge, buffer dropped, next imem_addr=0x40.
- irq=1 on delivery of pc 0x10 -> irq_ack pulse, epc=0x14, next imem_addr=0x100, in_isr=1; a second irq is ignored; mret -> imem_addr=0x14, in_isr=0.
- redirect_valid and mret and irq in the same cycle -> redirect target wins, in_isr unchanged, no irq_ack.
- imem_ready low for 4 cycles -> imem_addr stable, imem_req held, valid_out=0 bubbles; same with IF_IRQ_EN undefined: irq has no effect.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage. Owns the PC, requests instruction memory, and presents
//   the pc/instruction pair to the IF/ID register. It applies redirects, mret and irq traps.
// Latency: valid_out rises on the edge after imem_ready & !stall. Throughput is 1/cycle.
// Backpressure: stall holds all outputs. A response that arrives under stall is parked
//   in a one-entry skid buffer (HOLD).
// Optional feature macro: IF_IRQ_EN enables irq/mret/epc/in_isr. When it is undefined,
//   those inputs are ignored and epc, in_isr and irq_ack stay 0.
// Ports: clk, reset (async, active-high); stall, redirect_valid/redirect_pc, mret, irq in;
//   imem_req/imem_addr out, imem_ready/imem_rdata in;
//   pc_out, instruction_out, valid_out, epc, in_isr, irq_ack out.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        mret,
  input  logic        irq,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic [31:0] epc,
  output logic        in_isr,
  output logic        irq_ack
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        outstanding_q, outstanding_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_ins_q, skid_ins_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] ins_q, ins_d;
  logic        valid_q, valid_d;
  logic [31:0] epc_q, epc_d;
  logic        in_isr_q, in_isr_d;
  logic        irq_ack_q, irq_ack_d;

  logic        deliver;
  logic [31:0] dlv_pc, dlv_ins;
  logic        mret_take, trap_en;

`ifdef IF_IRQ_EN
  assign mret_take = mret & ~redirect_valid;
  assign trap_en   = irq & ~in_isr_q;
`else
  // Interrupt logic is absent. epc, in_isr and irq_ack never leave their reset value of 0.
  logic unused_irq_inputs;
  assign unused_irq_inputs = irq ^ mret;
  assign mret_take = 1'b0;
  assign trap_en   = 1'b0;
`endif

  // A request is held while a response is outstanding, so the address stays
  // stable even when decode stalls.
  assign imem_req  = (state_q == FETCH) & (~stall | outstanding_q);
  assign imem_addr = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    skid_pc_d     = skid_pc_q;
    skid_ins_d    = skid_ins_q;
    pc_out_d      = pc_out_q;
    ins_d         = ins_q;
    valid_d       = valid_q;
    epc_d         = epc_q;
    in_isr_d      = in_isr_q;
    irq_ack_d     = 1'b0;
    deliver       = 1'b0;
    dlv_pc        = pc_q;
    dlv_ins       = imem_rdata;

    if (redirect_valid) begin
      // Redirect overrides stall. Any parked instruction or in-flight access is dropped.
      pc_d          = redirect_pc;
      valid_d       = 1'b0;
      outstanding_d = 1'b0;
      state_d       = FETCH;
    end else if (mret_take) begin
      pc_d          = epc_q;
      valid_d       = 1'b0;
      outstanding_d = 1'b0;
      in_isr_d      = 1'b0;
      state_d       = FETCH;
    end else begin
      case (state_q)
        BOOT: state_d = FETCH;
        FETCH: begin
          outstanding_d = imem_req & ~imem_ready;
          if (imem_ready) begin
            pc_d = pc_q + 32'd4;
            if (stall) begin
              skid_pc_d  = pc_q;
              skid_ins_d = imem_rdata;
              state_d    = HOLD;
            end else begin
              deliver = 1'b1;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          // The PC already advanced past the parked instruction on capture.
          if (!stall) begin
            deliver = 1'b1;
            dlv_pc  = skid_pc_q;
            dlv_ins = skid_ins_q;
            state_d = FETCH;
          end
        end
        default: state_d = BOOT;
      endcase

      if (deliver) begin
        pc_out_d = dlv_pc;
        ins_d    = dlv_ins;
        valid_d  = 1'b1;
        // The trap is taken behind the instruction being delivered. The handler
        // returns to the instruction that follows it.
        if (trap_en) begin
          epc_d     = dlv_pc + 32'd4;
          pc_d      = IRQ_VECTOR;
          in_isr_d  = 1'b1;
          irq_ack_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= 1'b0;
      skid_pc_q     <= '0;
      skid_ins_q    <= '0;
      pc_out_q      <= '0;
      ins_q         <= '0;
      valid_q       <= 1'b0;
      epc_q         <= '0;
      in_isr_q      <= 1'b0;
      irq_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      skid_pc_q     <= skid_pc_d;
      skid_ins_q    <= skid_ins_d;
      pc_out_q      <= pc_out_d;
      ins_q         <= ins_d;
      valid_q       <= valid_d;
      epc_q         <= epc_d;
      in_isr_q      <= in_isr_d;
      irq_ack_q     <= irq_ack_d;
    end
  end

  assign pc_out          = pc_out_q;
  assign instruction_out = ins_q;
  assign valid_out       = valid_q;
  assign epc             = epc_q;
  assign in_isr          = in_isr_q;
  assign irq_ack         = irq_ack_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized and directed stimulus for if_fetch_unit.
// The reference model tracks the next fetch address, an optional parked instruction and the trap state.
// Memory answers with a fixed function of the address, whenever the bench raises imem_ready.
module tb_if_fetch_unit;

`ifdef IF_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] VEC    = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mret = 1'b0;
  logic        irq = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_out, instruction_out, epc;
  logic        valid_out, in_isr, irq_ack;

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mret(mret), .irq(irq),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instruction_out(instruction_out), .valid_out(valid_out),
    .epc(epc), .in_isr(in_isr), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Reference model state
  bit          m_boot, m_parked, m_pend, m_vld, m_isr, m_ack;
  logic [31:0] m_pc, m_park_pc, m_park_ins, m_pc_out, m_ins, m_epc;

  task automatic model_reset();
    m_boot = 1; m_parked = 0; m_pend = 0; m_vld = 0; m_isr = 0; m_ack = 0;
    m_pc = RST_PC; m_park_pc = '0; m_park_ins = '0; m_pc_out = '0; m_ins = '0; m_epc = '0;
  endtask

  task automatic check_outputs(input string ph);
    check_val({ph, ":pc_out"}, pc_out, m_pc_out);
    check_val({ph, ":instr"}, instruction_out, m_ins);
    check_val({ph, ":valid"}, {31'b0, valid_out}, {31'b0, m_vld});
    check_val({ph, ":epc"}, epc, m_epc);
    check_val({ph, ":in_isr"}, {31'b0, in_isr}, {31'b0, m_isr});
    check_val({ph, ":irq_ack"}, {31'b0, irq_ack}, {31'b0, m_ack});
  endtask

  // One clock cycle: called at a negedge and it returns at the next negedge.
  task automatic step(input bit s, input bit r, input bit rd, input logic [31:0] rpc,
                      input bit mr, input bit iq);
    bit          want_req, have;
    logic [31:0] dpc, dins;
    stall = s; imem_ready = r; redirect_valid = rd; redirect_pc = rpc; mret = mr; irq = iq;
    imem_rdata = mem_word(imem_addr);
    want_req = !m_boot && !m_parked && (!s || m_pend);
    #1;
    check_val("imem_req", {31'b0, imem_req}, {31'b0, want_req});
    check_val("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    have = 0; dpc = '0; dins = '0; m_ack = 0;
    if (rd) begin
      m_pc = rpc; m_vld = 0; m_parked = 0; m_boot = 0; m_pend = 0;
    end else if (IRQ_ON && mr) begin
      m_pc = m_epc; m_vld = 0; m_parked = 0; m_boot = 0; m_pend = 0; m_isr = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_parked) begin
      if (!s) begin have = 1; dpc = m_park_pc; dins = m_park_ins; m_parked = 0; end
    end else if (r) begin
      if (s) begin m_parked = 1; m_park_pc = m_pc; m_park_ins = mem_word(m_pc); end
      else begin have = 1; dpc = m_pc; dins = mem_word(m_pc); end
      m_pc = m_pc + 32'd4;
      m_pend = 0;
    end else begin
      if (want_req) m_pend = 1;
      if (!s) m_vld = 0;
    end
    if (have) begin
      m_pc_out = dpc; m_ins = dins; m_vld = 1;
      if (IRQ_ON && iq && !m_isr) begin
        m_epc = dpc + 32'd4; m_pc = VEC; m_isr = 1; m_ack = 1;
      end
    end
    #1;
    check_outputs("cyc");
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit s, input bit r, input bit iq);
    for (int i = 0; i < n; i++) step(s, r, 1'b0, '0, 1'b0, iq);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_0FFC);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, t,
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs("rst");
    check_val("rst:imem_req", {31'b0, imem_req}, 32'd0);
    check_val("rst:imem_addr", imem_addr, RST_PC);
    reset = 1'b0;

    // Boot, then back-to-back fetch 0x0 and 0x4
    run(3, 1'b0, 1'b1, 1'b0);
    // Response for 0x8 arrives under stall: park, hold, then release
    run(3, 1'b1, 1'b1, 1'b0);
    run(2, 1'b0, 1'b1, 1'b0);
    // Park again, then redirect to 0x40 while still stalled
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    run(2, 1'b0, 1'b1, 1'b0);
    // Memory not ready for four cycles, then ready
    run(4, 1'b0, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b1, 1'b0);
    // irq on the delivery of 0x10, a second irq, then mret
    step(1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    run(3, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    run(2, 1'b0, 1'b1, 1'b0);
    // redirect, mret and irq in the same cycle
    step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1);
    run(2, 1'b0, 1'b1, 1'b1);
    // Sequential PC wraps past 2^32
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    run(5, 1'b0, 1'b1, 1'b0);

    run_random(1500);

    // Asynchronous reset in the middle of traffic
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("midrst");
    check_val("midrst:imem_req", {31'b0, imem_req}, 32'd0);
    check_val("midrst:imem_addr", imem_addr, RST_PC);
    @(negedge clk);
    reset = 1'b0;
    run(3, 1'b0, 1'b1, 1'b0);
    run_random(400);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
